// File: rtl/mem_arbiter_if.sv
// Request/memory bundle for mem_arbiter: per-channel request lanes, response
// return path, and the single shared line-wide memory port.
`timescale 1ns/1ps
interface mem_arbiter_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
);
   logic [NUM_CH-1:0]        req_enable_i;
   logic [NUM_CH-1:0]        req_write_i;
   logic [NUM_CH*ADDR_W-1:0] req_addr_i;
   logic [NUM_CH*LINE_W-1:0] req_data_i;
   logic [NUM_CH-1:0]        resp_ack_o;
   logic [LINE_W-1:0]        resp_data_o;
   logic [NUM_CH-1:0]        grant_o;
   logic                     mem_enable_o;
   logic                     mem_write_o;
   logic [ADDR_W-1:0]        mem_addr_o;
   logic [LINE_W-1:0]        mem_data_o;
   logic [LINE_W-1:0]        mem_data_i;
   logic                     mem_ack_i;

   // Arbiter side
   modport slave (
      input  req_enable_i, req_write_i, req_addr_i, req_data_i, mem_data_i, mem_ack_i,
      output resp_ack_o, resp_data_o, grant_o,
             mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );

   // Cache controllers plus memory model side
   modport master (
      output req_enable_i, req_write_i, req_addr_i, req_data_i, mem_data_i, mem_ack_i,
      input  resp_ack_o, resp_data_o, grant_o,
             mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing one line-wide memory port among cache controllers.
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins priority.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256
) (
   input logic          clk_i,
   input logic          rst_i,
   mem_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_q, state_n;
   logic                mem_enable_q, mem_enable_n;
   logic                mem_write_q, mem_write_n;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_n;
   logic [LINE_W-1:0]   mem_data_q, mem_data_n;
   logic [NUM_CH-1:0]   resp_ack_q, resp_ack_n;
   logic [LINE_W-1:0]   resp_data_q, resp_data_n;
   logic [NUM_CH-1:0]   grant_q, grant_n;
   logic [PTR_W-1:0]    winner_c;
   logic                found_c;
   logic                any_req_c;

`ifndef ARB_FIXED_PRIO_EN
   logic [PTR_W-1:0]    last_ptr_q, last_ptr_n;
   logic [31:0]         idx_c;
`endif

   assign any_req_c = |bus.req_enable_i;

   // Winner select: first set request scanning from the search origin
   always_comb begin
      winner_c = '0;
      found_c  = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!found_c && bus.req_enable_i[PTR_W'(i)]) begin
            winner_c = PTR_W'(i);
            found_c  = 1'b1;
         end
      end
`else
      idx_c = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx_c = (32'(last_ptr_q) + i + 32'd1) % NUM_CH;
         if (!found_c && bus.req_enable_i[PTR_W'(idx_c)]) begin
            winner_c = PTR_W'(idx_c);
            found_c  = 1'b1;
         end
      end
`endif
   end

   // Next-state and registered-output values
   always_comb begin
      state_n      = state_q;
      mem_enable_n = mem_enable_q;
      mem_write_n  = mem_write_q;
      mem_addr_n   = mem_addr_q;
      mem_data_n   = mem_data_q;
      resp_ack_n   = resp_ack_q;
      resp_data_n  = resp_data_q;
      grant_n      = grant_q;
`ifndef ARB_FIXED_PRIO_EN
      last_ptr_n   = last_ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_req_c) begin
               state_n      = BUSY;
               mem_enable_n = 1'b1;
               mem_write_n  = bus.req_write_i[winner_c];
               mem_addr_n   = bus.req_addr_i[32'(winner_c)*ADDR_W +: ADDR_W];
               mem_data_n   = bus.req_data_i[32'(winner_c)*LINE_W +: LINE_W];
               grant_n      = NUM_CH'(1) << winner_c;
`ifndef ARB_FIXED_PRIO_EN
               last_ptr_n   = winner_c;
`endif
            end
         end
         BUSY: begin
            if (bus.mem_ack_i) begin
               state_n      = DONE;
               mem_enable_n = 1'b0;
               resp_ack_n   = grant_q;
               if (!mem_write_q) begin
                  resp_data_n = bus.mem_data_i;
               end
            end
         end
         DONE: begin
            // Acked channel still holds its enable here, so no arbitration yet
            state_n    = IDLE;
            resp_ack_n = '0;
            grant_n    = '0;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         resp_ack_q   <= '0;
         resp_data_q  <= '0;
         grant_q      <= '0;
`ifndef ARB_FIXED_PRIO_EN
         last_ptr_q   <= PTR_W'(NUM_CH - 1);
`endif
      end else begin
         state_q      <= state_n;
         mem_enable_q <= mem_enable_n;
         mem_write_q  <= mem_write_n;
         mem_addr_q   <= mem_addr_n;
         mem_data_q   <= mem_data_n;
         resp_ack_q   <= resp_ack_n;
         resp_data_q  <= resp_data_n;
         grant_q      <= grant_n;
`ifndef ARB_FIXED_PRIO_EN
         last_ptr_q   <= last_ptr_n;
`endif
      end
   end

   assign bus.mem_enable_o = mem_enable_q;
   assign bus.mem_write_o  = mem_write_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_data_o   = mem_data_q;
   assign bus.resp_ack_o   = resp_ack_q;
   assign bus.resp_data_o  = resp_data_q;
   assign bus.grant_o      = grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (NUM_CH=4): directed scenarios push expected
// grants/responses; a monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LINE_W = 256;

   typedef struct {
      int unsigned       ch;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   txn_t              exp_grant[$];
   txn_t              exp_resp[$];
   int                n_vec = 0;
   int                n_err = 0;
   logic [ADDR_W-1:0] ch_addr[NUM_CH];
   logic              ch_wr[NUM_CH];
   logic [LINE_W-1:0] ch_data[NUM_CH];
   int unsigned       target[NUM_CH];
   int unsigned       acks[NUM_CH];
   int                mem_lat;
   int                spur_req;

   function automatic logic [LINE_W-1:0] memline(input logic [ADDR_W-1:0] a);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = a ^ (32'h5A5A_0000 + 32'(i));
      return l;
   endfunction

   function automatic logic [NUM_CH-1:0] onehot(input int unsigned c);
      return NUM_CH'(1) << c;
   endfunction

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic push(input int unsigned c, input logic with_resp);
      txn_t t;
      t.ch = c; t.wr = ch_wr[c]; t.addr = ch_addr[c]; t.data = ch_data[c];
      exp_grant.push_back(t);
      if (with_resp) exp_resp.push_back(t);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_enable"}, LINE_W'(bus.mem_enable_o), '0);
      check({tag, "_mem_write"},  LINE_W'(bus.mem_write_o),  '0);
      check({tag, "_mem_addr"},   LINE_W'(bus.mem_addr_o),   '0);
      check({tag, "_mem_data"},   bus.mem_data_o,            '0);
      check({tag, "_resp_ack"},   LINE_W'(bus.resp_ack_o),   '0);
      check({tag, "_resp_data"},  bus.resp_data_o,           '0);
      check({tag, "_grant"},      LINE_W'(bus.grant_o),      '0);
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      bit ok = 1'b0;
      for (int k = 0; k < max_cyc && !ok; k++) begin
         @(negedge clk);
         ok = (exp_grant.size() == 0) && (exp_resp.size() == 0) &&
              !bus.mem_enable_o && (bus.resp_ack_o == '0);
         for (int c = 0; c < NUM_CH; c++) if (acks[c] != target[c]) ok = 1'b0;
      end
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, max_cyc);
      end
      repeat (2) @(negedge clk);
   endtask

   // Requester model: each channel holds its enable until its ack count reaches target
   initial begin
      bus.req_enable_i = '0;
      bus.req_write_i  = '0;
      bus.req_addr_i   = '0;
      bus.req_data_i   = '0;
      for (int c = 0; c < NUM_CH; c++) acks[c] = 0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.resp_ack_o[c]) acks[c]++;
            bus.req_enable_i[c] = (acks[c] < target[c]);
            bus.req_write_i[c]  = ch_wr[c];
            bus.req_addr_i[c*ADDR_W +: ADDR_W] = ch_addr[c];
            bus.req_data_i[c*LINE_W +: LINE_W] = ch_data[c];
         end
      end
   end

   // Memory model: acks mem_lat cycles after seeing enable; keeps counting across a reset
   initial begin
      bit                busy;
      int                cnt;
      int                spur_done;
      logic [ADDR_W-1:0] a;
      busy = 1'b0; cnt = 0; spur_done = 0; a = '0;
      bus.mem_ack_i  = 1'b0;
      bus.mem_data_i = '0;
      forever begin
         @(negedge clk);
         bus.mem_ack_i  = 1'b0;
         bus.mem_data_i = ~memline(a);
         if (spur_req != spur_done) begin
            spur_done      = spur_req;
            bus.mem_ack_i  = 1'b1;
            bus.mem_data_i = '1;
         end else if (busy) begin
            cnt--;
            if (cnt <= 0) begin
               busy           = 1'b0;
               bus.mem_ack_i  = 1'b1;
               bus.mem_data_i = memline(a);
            end
         end else if (bus.mem_enable_o) begin
            busy = 1'b1;
            cnt  = mem_lat;
            a    = bus.mem_addr_o;
         end
      end
   end

   // Monitor: grants checked on enable rise, hold checked on fall, responses on ack
   initial begin
      logic              en_prev, stable, rst_at_edge;
      logic [NUM_CH-1:0] cur_grant;
      logic [ADDR_W-1:0] cur_addr;
      logic [LINE_W-1:0] cur_data, last_rd;
      logic              cur_wr;
      txn_t              t;
      en_prev = 1'b0; stable = 1'b1; last_rd = '0;
      cur_grant = '0; cur_addr = '0; cur_data = '0; cur_wr = 1'b0;
      forever begin
         @(posedge clk);
         rst_at_edge = rst;
         @(negedge clk);
         if (!rst_at_edge) last_rd = '0;
         if (bus.mem_enable_o && !en_prev) begin
            if (exp_grant.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL grant_unexpected: got grant %b, required none", bus.grant_o);
            end else begin
               t = exp_grant.pop_front();
               check("grant", LINE_W'(bus.grant_o), LINE_W'(onehot(t.ch)));
               check("mem_write", LINE_W'(bus.mem_write_o), LINE_W'(t.wr));
               check("mem_addr", LINE_W'(bus.mem_addr_o), LINE_W'(t.addr));
               check("mem_data", bus.mem_data_o, t.data);
            end
            cur_grant = bus.grant_o; cur_addr = bus.mem_addr_o;
            cur_data  = bus.mem_data_o; cur_wr = bus.mem_write_o;
            stable    = 1'b1;
         end else if (bus.mem_enable_o) begin
            if (bus.grant_o !== cur_grant || bus.mem_addr_o !== cur_addr ||
                bus.mem_data_o !== cur_data || bus.mem_write_o !== cur_wr) stable = 1'b0;
         end else if (en_prev) begin
            check("mem_hold_stable", LINE_W'(stable), LINE_W'(1'b1));
         end
         en_prev = bus.mem_enable_o;
         if (bus.resp_ack_o != '0) begin
            check("enable_low_at_ack", LINE_W'(bus.mem_enable_o), '0);
            if (exp_resp.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL resp_unexpected: got resp_ack %b, required none", bus.resp_ack_o);
            end else begin
               t = exp_resp.pop_front();
               check("resp_ack", LINE_W'(bus.resp_ack_o), LINE_W'(onehot(t.ch)));
               if (t.wr) begin
                  check("resp_data_wr_hold", bus.resp_data_o, last_rd);
               end else begin
                  check("resp_data_rd", bus.resp_data_o, memline(t.addr));
                  last_rd = memline(t.addr);
               end
            end
         end
      end
   end

   // Directed scenarios
   initial begin
      bit got;
      for (int c = 0; c < NUM_CH; c++) begin
         target[c]  = 0;
         ch_addr[c] = 32'h0000_1000 * 32'(c + 1);
         ch_wr[c]   = 1'b0;
         ch_data[c] = {8{32'hD00D_0000 | 32'(c)}};
      end
      mem_lat = 3; spur_req = 0; rst = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;

      // Spurious ack while idle
      repeat (2) @(negedge clk);
      spur_req++;
      repeat (4) @(negedge clk);
      check("spur_resp_ack", LINE_W'(bus.resp_ack_o), '0);
      check("spur_grant", LINE_W'(bus.grant_o), '0);
      check("spur_enable", LINE_W'(bus.mem_enable_o), '0);

      // Single read from ch0, memory latency 10
      ch_addr[0] = 32'h0000_0400; mem_lat = 10;
      push(0, 1'b1);
      target[0] += 1;
      wait_done("single", 200);

      // Contention ch0 (read) vs ch1 (write)
      ch_addr[0] = 32'h0000_2000; ch_addr[1] = 32'h0000_3000; ch_wr[1] = 1'b1;
      mem_lat = 2;
`ifdef ARB_FIXED_PRIO_EN
      push(0, 1'b1); push(0, 1'b1); push(1, 1'b1); push(1, 1'b1);
`else
      push(1, 1'b1); push(0, 1'b1); push(1, 1'b1); push(0, 1'b1);
`endif
      target[0] += 2; target[1] += 2;
      wait_done("contention", 300);

      // Wrap: channels 1 and 3
      ch_wr[1] = 1'b0; ch_addr[1] = 32'h0000_5000; ch_addr[3] = 32'h0000_7000;
      mem_lat = 1;
`ifdef ARB_FIXED_PRIO_EN
      push(1, 1'b1); push(1, 1'b1); push(3, 1'b1); push(3, 1'b1);
`else
      push(1, 1'b1); push(3, 1'b1); push(1, 1'b1); push(3, 1'b1);
`endif
      target[1] += 2; target[3] += 2;
      wait_done("wrap", 300);

      // Lone requester re-granted on each idle visit
      ch_addr[2] = 32'h0000_6000; mem_lat = 4;
      push(2, 1'b1); push(2, 1'b1);
      target[2] += 2;
      wait_done("regrant", 200);

      // Reset 3 cycles into a BUSY transaction; late memory ack must be ignored
      ch_addr[2] = 32'h0000_6800; mem_lat = 20;
      push(2, 1'b0);
      target[2] += 1;
      got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = bus.mem_enable_o;
      end
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL rst_busy_grant_timeout: enable %b, required 1", bus.mem_enable_o);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      target[2] = acks[2];
      @(negedge clk);
      check_all_zero("mid_busy_reset");
      rst = 1'b1;
      repeat (25) @(negedge clk);
      check("late_ack_grant", LINE_W'(bus.grant_o), '0);

      // Fresh ch1 write after reset: resp_data stays at its reset value
      ch_addr[1] = 32'h0000_9000; ch_wr[1] = 1'b1; mem_lat = 3;
      push(1, 1'b1);
      target[1] += 1;
      wait_done("post_reset", 200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
